// File: rtl/alu_issue_ctrl_if.sv
// Issue-side handshake bundle for alu_issue_ctrl.
// master: the issuing stage or bench. It drives in_valid, is_imm, funct3, funct7,
//         tag_in and out_ready.
// slave : alu_issue_ctrl. It drives in_ready, select, control, unit_start,
//         unit_kill, busy, illegal, out_valid and tag_out.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             is_imm;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [TAG_W-1:0] tag_in;
    logic [2:0]       select;
    logic [1:0]       control;
    logic             unit_start;
    logic             unit_kill;
    logic             busy;
    logic             illegal;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, is_imm, funct3, funct7, tag_in, out_ready,
        input  in_ready, select, control, unit_start, unit_kill, busy,
               illegal, out_valid, tag_out
    );

    modport slave (
        input  in_valid, is_imm, funct3, funct7, tag_in, out_ready,
        output in_ready, select, control, unit_start, unit_kill, busy,
               illegal, out_valid, tag_out
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Registered decode and issue sequencer for the execute stage.
// It accepts one R-type or I-type op over valid/ready and decodes it to the ALU
// {select,control} code. It pulses unit_start, counts the unit latency, and holds
// out_valid with the tag until downstream accepts the result. At most one op is
// in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   flush : synchronous kill of the in-flight op
//   bus   : alu_issue_ctrl_if.slave, which carries the op input, the unit
//           controls and the result handshake
module alu_issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int TAG_W   = 5,
    parameter bit EN_M    = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    input logic            flush,
    alu_issue_ctrl_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       sel_q;
    logic [1:0]       ctl_q;
    logic [TAG_W-1:0] tag_q;
    logic             ill_q;
    logic             start_q;
    logic             kill_q;

    logic [2:0]       dec_sel;
    logic [1:0]       dec_ctl;
    logic             dec_ill;
    logic [CW-1:0]    dec_cnt;
    logic             accept;

    // Reset and flush both gate in_ready so that no accept can slip through
    // in either condition.
    assign bus.in_ready = rst_n & ~flush &
                          ((state == IDLE) | ((state == DONE) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.select     = sel_q;
    assign bus.control    = ctl_q;
    assign bus.tag_out    = tag_q;
    assign bus.illegal    = ill_q;
    assign bus.unit_start = start_q;
    assign bus.unit_kill  = kill_q;
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);

    always_comb begin
        dec_sel = '0;
        dec_ctl = '0;
        dec_ill = 1'b0;
        if (bus.is_imm) begin
            // For I-type ops, funct7 only matters for the two shift encodings.
            case (bus.funct3)
                3'b000: begin dec_sel = 3'b000; dec_ctl = 2'b00; end
                3'b010: begin dec_sel = 3'b000; dec_ctl = 2'b10; end
                3'b011: begin dec_sel = 3'b000; dec_ctl = 2'b11; end
                3'b100: begin dec_sel = 3'b101; dec_ctl = 2'b00; end
                3'b110: begin dec_sel = 3'b110; dec_ctl = 2'b00; end
                3'b111: begin dec_sel = 3'b111; dec_ctl = 2'b00; end
                3'b001: begin
                    if (bus.funct7 == F7_BASE) dec_sel = 3'b011;
                    else                       dec_ill = 1'b1;
                end
                default: begin
                    if (bus.funct7 == F7_BASE)     dec_sel = 3'b100;
                    else if (bus.funct7 == F7_ALT) begin
                        dec_sel = 3'b100;
                        dec_ctl = 2'b01;
                    end else                       dec_ill = 1'b1;
                end
            endcase
        end else if (bus.funct7 == F7_BASE) begin
            case (bus.funct3)
                3'b000: begin dec_sel = 3'b000; dec_ctl = 2'b00; end
                3'b001: begin dec_sel = 3'b011; dec_ctl = 2'b00; end
                3'b010: begin dec_sel = 3'b000; dec_ctl = 2'b10; end
                3'b011: begin dec_sel = 3'b000; dec_ctl = 2'b11; end
                3'b100: begin dec_sel = 3'b101; dec_ctl = 2'b00; end
                3'b101: begin dec_sel = 3'b100; dec_ctl = 2'b00; end
                3'b110: begin dec_sel = 3'b110; dec_ctl = 2'b00; end
                default: begin dec_sel = 3'b111; dec_ctl = 2'b00; end
            endcase
        end else if (bus.funct7 == F7_ALT) begin
            if (bus.funct3 == 3'b000)      begin dec_sel = 3'b000; dec_ctl = 2'b01; end
            else if (bus.funct3 == 3'b101) begin dec_sel = 3'b100; dec_ctl = 2'b01; end
            else                           dec_ill = 1'b1;
        end else if ((bus.funct7 == F7_M) && EN_M) begin
            // In the M group, funct3[2] picks mul or div and funct3[1:0] is the sub-op.
            dec_sel = bus.funct3[2] ? 3'b010 : 3'b001;
            dec_ctl = bus.funct3[1:0];
        end else begin
            dec_ill = 1'b1;
        end
    end

    always_comb begin
        dec_cnt = '0;
        if (dec_sel == 3'b001)      dec_cnt = MUL_CNT;
        else if (dec_sel == 3'b010) dec_cnt = DIV_CNT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            ctl_q   <= '0;
            tag_q   <= '0;
            ill_q   <= 1'b0;
            start_q <= 1'b0;
            kill_q  <= 1'b0;
        end else if (flush) begin
            kill_q  <= (state != IDLE);
            start_q <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            ill_q   <= 1'b0;
        end else begin
            kill_q  <= 1'b0;
            start_q <= accept;
            if (accept) begin
                // This covers accepts from IDLE and from DONE with out_ready,
                // where the old result retires on the same edge the new op is taken.
                sel_q <= dec_sel;
                ctl_q <= dec_ctl;
                tag_q <= bus.tag_in;
                ill_q <= dec_ill;
                cnt   <= dec_cnt;
                state <= BUSY;
            end else begin
                case (state)
                    BUSY: begin
                        if (cnt == '0) state <= DONE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    DONE: begin
                        if (bus.out_ready) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;
    logic flush;
    int unsigned n_chk;
    int unsigned n_bad;

    alu_issue_ctrl_if #(.TAG_W(5)) b1 ();
    alu_issue_ctrl_if #(.TAG_W(5)) b2 ();

    alu_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(32), .TAG_W(5), .EN_M(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1)
    );

    alu_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(32), .TAG_W(5), .EN_M(1'b0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2)
    );

    assign b2.in_valid  = b1.in_valid;
    assign b2.is_imm    = b1.is_imm;
    assign b2.funct3    = b1.funct3;
    assign b2.funct7    = b1.funct7;
    assign b2.tag_in    = b1.tag_in;
    assign b2.out_ready = b1.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, check that it is accepted, and drop in_valid after the edge.
    task automatic issue(input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] t);
        b1.is_imm   = imm;
        b1.funct3   = f3;
        b1.funct7   = f7;
        b1.tag_in   = t;
        b1.in_valid = 1'b1;
        #1;
        check("in_ready_before_accept", 32'(b1.in_ready), 32'd1);
        tick();
        b1.in_valid = 1'b0;
    endtask

    task automatic drain();
        b1.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!b1.busy && !b2.busy) break;
        end
        check("drain_idle", 32'({b1.busy, b2.busy}), 32'd0);
        b1.out_ready = 1'b0;
    endtask

    task automatic decode_case(input string name, input logic imm, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [2:0] es,
                               input logic [1:0] ec, input logic ei);
        issue(imm, f3, f7, 5'd1);
        check({name, "_sel"}, 32'(b1.select), 32'(es));
        check({name, "_ctl"}, 32'(b1.control), 32'(ec));
        check({name, "_ill"}, 32'(b1.illegal), 32'(ei));
        drain();
    endtask

    initial begin
        logic seen;
        int unsigned n_acc;
        int unsigned n_out;
        int last_acc;
        logic acc;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        b1.in_valid  = 1'b1;
        b1.is_imm    = 1'b0;
        b1.funct3    = 3'b000;
        b1.funct7    = 7'b0000000;
        b1.tag_in    = 5'd0;
        b1.out_ready = 1'b0;

        // Hold reset with in_valid high: nothing may be accepted.
        repeat (3) tick();
        check("rst_busy", 32'(b1.busy), 32'd0);
        check("rst_out_valid", 32'(b1.out_valid), 32'd0);
        check("rst_sel", 32'(b1.select), 32'd0);
        check("rst_ctl", 32'(b1.control), 32'd0);
        check("rst_in_ready", 32'(b1.in_ready), 32'd0);
        rst_n = 1'b1;
        b1.in_valid = 1'b0;
        tick();
        check("post_rst_busy", 32'(b1.busy), 32'd0);

        // R-type sub: latency 1.
        issue(1'b0, 3'b000, 7'b0100000, 5'd7);
        check("sub_start", 32'(b1.unit_start), 32'd1);
        check("sub_sel", 32'(b1.select), 32'd0);
        check("sub_ctl", 32'(b1.control), 32'd1);
        check("sub_tag", 32'(b1.tag_out), 32'd7);
        check("sub_ov_early", 32'(b1.out_valid), 32'd0);
        tick();
        check("sub_ov", 32'(b1.out_valid), 32'd1);
        check("sub_start_clr", 32'(b1.unit_start), 32'd0);
        drain();

        // mulhu: valid at +3 on the EN_M instance; illegal on the EN_M=0 instance.
        issue(1'b0, 3'b011, 7'b0000001, 5'd3);
        check("mul_start", 32'(b1.unit_start), 32'd1);
        check("mul_sel", 32'(b1.select), 32'd1);
        check("mul_ctl", 32'(b1.control), 32'd3);
        check("nom_ill", 32'(b2.illegal), 32'd1);
        check("nom_selctl", 32'({b2.select, b2.control}), 32'd0);
        tick();
        check("mul_ov_p1", 32'(b1.out_valid), 32'd0);
        check("nom_ov_p1", 32'(b2.out_valid), 32'd1);
        tick();
        check("mul_ov_p2", 32'(b1.out_valid), 32'd0);
        tick();
        check("mul_ov_p3", 32'(b1.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mul_hold", 32'({b1.out_valid, b1.select, b1.control, b1.tag_out}),
                  32'({1'b1, 3'b001, 2'b11, 5'd3}));
        end
        drain();

        // div flushed after 10 cycles: one kill pulse, and the result never appears.
        issue(1'b0, 3'b100, 7'b0000001, 5'd9);
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            seen |= b1.out_valid;
            tick();
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(b1.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("div_kill", 32'(b1.unit_kill), 32'd1);
        check("div_busy", 32'(b1.busy), 32'd0);
        check("div_start_kill", 32'(b1.unit_start), 32'd0);
        tick();
        check("div_kill_clr", 32'(b1.unit_kill), 32'd0);
        for (int i = 0; i < 30; i++) begin
            seen |= b1.out_valid;
            tick();
        end
        check("div_no_ov", 32'(seen), 32'd0);

        // Flush in IDLE with in_valid high: no accept and no kill.
        b1.in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("idle_flush_rdy", 32'(b1.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        b1.in_valid = 1'b0;
        check("idle_flush_state", 32'({b1.busy, b1.unit_kill, b1.unit_start}), 32'd0);

        // Flush beats out_ready in DONE, so the result is dropped.
        issue(1'b0, 3'b110, 7'b0000000, 5'd4);
        tick();
        check("done_ov", 32'(b1.out_valid), 32'd1);
        flush = 1'b1;
        b1.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        b1.out_ready = 1'b0;
        check("done_flush", 32'({b1.unit_kill, b1.out_valid, b1.busy}), 32'b100);

        // I-type and R-type decode corners.
        decode_case("i_add",  1'b1, 3'b000, 7'b0100000, 3'b000, 2'b00, 1'b0);
        decode_case("i_sra",  1'b1, 3'b101, 7'b0100000, 3'b100, 2'b01, 1'b0);
        decode_case("i_sll7", 1'b1, 3'b001, 7'b0100000, 3'b000, 2'b00, 1'b1);
        decode_case("i_sltu", 1'b1, 3'b011, 7'b1111111, 3'b000, 2'b11, 1'b0);
        decode_case("r_and",  1'b0, 3'b111, 7'b0000000, 3'b111, 2'b00, 1'b0);
        decode_case("r_srl",  1'b0, 3'b101, 7'b0000000, 3'b100, 2'b00, 1'b0);
        decode_case("r_sll7", 1'b0, 3'b001, 7'b0100000, 3'b000, 2'b00, 1'b1);
        decode_case("r_badf7", 1'b0, 3'b000, 7'b0000010, 3'b000, 2'b00, 1'b1);
        decode_case("r_remu", 1'b0, 3'b111, 7'b0000001, 3'b010, 2'b11, 1'b0);

        // Stream of 10 ALU ops: one accept every 2 cycles, with tags in order.
        b1.is_imm = 1'b0;
        b1.funct3 = 3'b000;
        b1.funct7 = 7'b0000000;
        b1.out_ready = 1'b1;
        n_acc = 0;
        n_out = 0;
        last_acc = -1;
        for (int cyc = 0; cyc < 60 && n_out < 10; cyc++) begin
            b1.in_valid = (n_acc < 10);
            b1.tag_in = 5'(10 + n_acc);
            #1;
            acc = b1.in_valid & b1.in_ready;
            if (b1.out_valid) begin
                check("stream_tag", 32'(b1.tag_out), 32'(10 + n_out));
                n_out++;
            end
            if (acc) begin
                if (last_acc >= 0) check("stream_gap", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                n_acc++;
            end
            tick();
        end
        b1.in_valid = 1'b0;
        check("stream_acc", 32'(n_acc), 32'd10);
        check("stream_out", 32'(n_out), 32'd10);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
